// File: rtl/vga_console_if.sv
// Upstream byte channel of the VGA text console: a valid/ready byte
// stream plus the colors that go with each byte.
interface vga_console_if;
  logic        charValid;
  logic [7:0]  charCode;
  logic        charReady;
  logic [23:0] fgColor;
  logic [23:0] bgColor;

  modport master (
    output charValid, charCode, fgColor, bgColor,
    input  charReady
  );

  modport slave (
    input  charValid, charCode, fgColor, bgColor,
    output charReady
  );
endinterface

// File: rtl/vga_console.sv
// Text console front end: turns a byte stream into cell writes for a VGA
// character buffer. Define VGA_CONSOLE_CLEAR_ON_WRAP_EN to blank each new row.
module vga_console #(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 24,
  parameter logic [7:0] BLANK = 8'h00
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        charValid,
  input  logic [7:0]  charCode,
  output logic        charReady,
  input  logic [23:0] fgColor,
  input  logic [23:0] bgColor,
  output logic        charWr,
  output logic [23:0] charWrFgColor,
  output logic [23:0] charWrBgColor,
  output logic [7:0]  charWrCode,
  output logic [5:0]  charWrX,
  output logic [4:0]  charWrY,
  output logic [5:0]  cursorX,
  output logic [4:0]  cursorY
);

  typedef enum logic [1:0] {
    IDLE,
    CLR_SCREEN,
    CLR_ROW
  } state_t;

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic [5:0]  curX_q, curX_d;
  logic [4:0]  curY_q, curY_d;
  logic [5:0]  clrX_q, clrX_d;
  logic [4:0]  clrY_q, clrY_d;
  logic [23:0] fg_q, fg_d;
  logic [23:0] bg_q, bg_d;
  logic        wr_q, wr_d;
  logic [7:0]  wrCode_q, wrCode_d;
  logic [5:0]  wrX_q, wrX_d;
  logic [4:0]  wrY_q, wrY_d;
  logic [23:0] wrFg_q, wrFg_d;
  logic [23:0] wrBg_q, wrBg_d;
  logic [4:0]  yInc;
  logic        printable;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= CLR_SCREEN;
      curX_q   <= '0;
      curY_q   <= '0;
      clrX_q   <= '0;
      clrY_q   <= '0;
      fg_q     <= 24'hFFFFFF;
      bg_q     <= '0;
      wr_q     <= 1'b0;
      wrCode_q <= '0;
      wrX_q    <= '0;
      wrY_q    <= '0;
      wrFg_q   <= 24'hFFFFFF;
      wrBg_q   <= '0;
    end else begin
      state_q  <= state_d;
      curX_q   <= curX_d;
      curY_q   <= curY_d;
      clrX_q   <= clrX_d;
      clrY_q   <= clrY_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      wr_q     <= wr_d;
      wrCode_q <= wrCode_d;
      wrX_q    <= wrX_d;
      wrY_q    <= wrY_d;
      wrFg_q   <= wrFg_d;
      wrBg_q   <= wrBg_d;
    end
  end

  assign yInc      = (curY_q == YMAX) ? '0 : curY_q + 5'd1;
  assign printable = (charCode >= 8'h20) && (charCode <= 8'h7E);

  always_comb begin
    state_d  = state_q;
    curX_d   = curX_q;
    curY_d   = curY_q;
    clrX_d   = clrX_q;
    clrY_d   = clrY_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    wr_d     = 1'b0;
    wrCode_d = wrCode_q;
    wrX_d    = wrX_q;
    wrY_d    = wrY_q;
    wrFg_d   = wrFg_q;
    wrBg_d   = wrBg_q;
    unique case (state_q)
      CLR_SCREEN, CLR_ROW: begin
        wr_d     = 1'b1;
        wrCode_d = BLANK;
        wrX_d    = clrX_q;
        wrY_d    = clrY_q;
        wrFg_d   = fg_q;
        wrBg_d   = bg_q;
        if (clrX_q == XMAX) begin
          clrX_d = '0;
          if (state_q == CLR_ROW) begin
            state_d = IDLE;
          end else if (clrY_q == YMAX) begin
            clrY_d  = '0;
            state_d = IDLE;
            curX_d  = '0;
            curY_d  = '0;
          end else begin
            clrY_d = clrY_q + 5'd1;
          end
        end else begin
          clrX_d = clrX_q + 6'd1;
        end
      end
      default: begin
        if (charValid) begin
          unique case (1'b1)
            printable: begin
              wr_d     = 1'b1;
              wrCode_d = charCode;
              wrX_d    = curX_q;
              wrY_d    = curY_q;
              wrFg_d   = fgColor;
              wrBg_d   = bgColor;
              if (curX_q == XMAX) begin
                curX_d = '0;
                curY_d = yInc;
`ifdef VGA_CONSOLE_CLEAR_ON_WRAP_EN
                state_d = CLR_ROW;
                clrX_d  = '0;
                clrY_d  = yInc;
                fg_d    = fgColor;
                bg_d    = bgColor;
`endif
              end else begin
                curX_d = curX_q + 6'd1;
              end
            end
            (charCode == 8'h0A): begin
              curX_d = '0;
              curY_d = yInc;
`ifdef VGA_CONSOLE_CLEAR_ON_WRAP_EN
              state_d = CLR_ROW;
              clrX_d  = '0;
              clrY_d  = yInc;
              fg_d    = fgColor;
              bg_d    = bgColor;
`endif
            end
            (charCode == 8'h0D): curX_d = '0;
            (charCode == 8'h08): begin
              // Backspace steps back first, then blanks the cell it lands on
              if (curX_q != '0) begin
                curX_d   = curX_q - 6'd1;
                wr_d     = 1'b1;
                wrX_d    = curX_q - 6'd1;
                wrY_d    = curY_q;
                wrCode_d = BLANK;
                wrFg_d   = fgColor;
                wrBg_d   = bgColor;
              end else if (curY_q != '0) begin
                curX_d   = XMAX;
                curY_d   = curY_q - 5'd1;
                wr_d     = 1'b1;
                wrX_d    = XMAX;
                wrY_d    = curY_q - 5'd1;
                wrCode_d = BLANK;
                wrFg_d   = fgColor;
                wrBg_d   = bgColor;
              end
            end
            (charCode == 8'h0C): begin
              state_d = CLR_SCREEN;
              clrX_d  = '0;
              clrY_d  = '0;
              fg_d    = fgColor;
              bg_d    = bgColor;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign charReady     = (state_q == IDLE);
  assign charWr        = wr_q;
  assign charWrCode    = wrCode_q;
  assign charWrX       = wrX_q;
  assign charWrY       = wrY_q;
  assign charWrFgColor = wrFg_q;
  assign charWrBgColor = wrBg_q;
  assign cursorX       = curX_q;
  assign cursorY       = curY_q;

endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console: table of single-byte vectors plus
// hand sequences for reset clear, wrap, form feed and mid-clear reset.
module tb_vga_console;
  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        charWr;
  logic [23:0] charWrFgColor, charWrBgColor;
  logic [7:0]  charWrCode;
  logic [5:0]  charWrX, cursorX;
  logic [4:0]  charWrY, cursorY;

  vga_console_if ifc ();

  vga_console dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .charValid     (ifc.charValid),
    .charCode      (ifc.charCode),
    .charReady     (ifc.charReady),
    .fgColor       (ifc.fgColor),
    .bgColor       (ifc.bgColor),
    .charWr        (charWr),
    .charWrFgColor (charWrFgColor),
    .charWrBgColor (charWrBgColor),
    .charWrCode    (charWrCode),
    .charWrX       (charWrX),
    .charWrY       (charWrY),
    .cursorX       (cursorX),
    .cursorY       (cursorY)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] K = 24'h000000;

  typedef struct {
    logic [7:0]  code;
    logic [23:0] fg;
    logic [23:0] bg;
    logic        wr;
    logic [7:0]  ecode;
    logic [5:0]  ex;
    logic [4:0]  ey;
    logic [5:0]  cx;
    logic [4:0]  cy;
  } vec_t;

  vec_t vt [18];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, a, e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] c, input logic [23:0] f,
                      input logic [23:0] b);
    int n = 0;
    while (!ifc.charReady && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 5000) chk("send_ready_timeout", 32'(n), 32'd0);
    ifc.charValid = 1'b1;
    ifc.charCode  = c;
    ifc.fgColor   = f;
    ifc.bgColor   = b;
    @(posedge CLOCK_50);
    #1 ifc.charValid = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Called at the first negedge where a clear write may be visible.
  task automatic wait_clear(input logic [23:0] f, input logic [23:0] b);
    int n = 0;
    int bad = 0;
    int it = 0;
    logic [5:0] lx = '0;
    logic [4:0] ly = '0;
    while (it < 2000) begin
      if (charWr) begin
        if (charWrX != 6'(n % 64) || charWrY != 5'(n / 64) ||
            charWrCode != 8'h00 || charWrFgColor != f ||
            charWrBgColor != b)
          bad++;
        lx = charWrX;
        ly = charWrY;
        n++;
      end
      if (ifc.charReady) break;
      @(negedge CLOCK_50);
      it++;
    end
    chk("clr_count", 32'(n), 32'd1536);
    chk("clr_order", 32'(bad), 32'd0);
    chk("clr_last_x", 32'(lx), 32'd63);
    chk("clr_last_y", 32'(ly), 32'd23);
    chk("clr_ready", 32'(ifc.charReady), 32'd1);
    chk("clr_cur_x", 32'(cursorX), 32'd0);
    chk("clr_cur_y", 32'(cursorY), 32'd0);
  endtask

  initial begin
    int n42;
    int nclr;
    int it;
    logic done;

    vt[0]  = '{8'h0A, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd1};
    vt[1]  = '{8'h0A, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd2};
    vt[2]  = '{8'h0A, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd3};
    vt[3]  = '{8'h20, W, K, 1'b1, 8'h20,  6'd0, 5'd3,  6'd1, 5'd3};
    vt[4]  = '{8'h7E, W, K, 1'b1, 8'h7E,  6'd1, 5'd3,  6'd2, 5'd3};
    vt[5]  = '{8'h7F, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd2, 5'd3};
    vt[6]  = '{8'h1F, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd2, 5'd3};
    vt[7]  = '{8'h30, W, K, 1'b1, 8'h30,  6'd2, 5'd3,  6'd3, 5'd3};
    vt[8]  = '{8'h31, W, K, 1'b1, 8'h31,  6'd3, 5'd3,  6'd4, 5'd3};
    vt[9]  = '{8'h32, W, K, 1'b1, 8'h32,  6'd4, 5'd3,  6'd5, 5'd3};
    vt[10] = '{8'h41, 24'hFF0000, 24'h0000FF,
               1'b1, 8'h41,  6'd5, 5'd3,  6'd6, 5'd3};
    vt[11] = '{8'h08, W, K, 1'b1, 8'h00,  6'd5, 5'd3,  6'd5, 5'd3};
    vt[12] = '{8'h0D, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd3};
    vt[13] = '{8'h08, W, K, 1'b1, 8'h00, 6'd63, 5'd2, 6'd63, 5'd2};
    vt[14] = '{8'h0A, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd3};
    vt[15] = '{8'h0A, W, K, 1'b0, 8'h00,  6'd0, 5'd0,  6'd0, 5'd4};
    vt[16] = '{8'h08, W, K, 1'b1, 8'h00, 6'd63, 5'd3, 6'd63, 5'd3};
    vt[17] = '{8'h43, W, K, 1'b1, 8'h43, 6'd63, 5'd3,  6'd0, 5'd4};

    ifc.charValid = 1'b0;
    ifc.charCode  = 8'h00;
    ifc.fgColor   = W;
    ifc.bgColor   = K;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_wr", 32'(charWr), 32'd0);
    chk("rst_code", 32'(charWrCode), 32'd0);
    chk("rst_x", 32'(charWrX), 32'd0);
    chk("rst_y", 32'(charWrY), 32'd0);
    chk("rst_fg", 32'(charWrFgColor), 32'hFFFFFF);
    chk("rst_bg", 32'(charWrBgColor), 32'd0);
    chk("rst_ready", 32'(ifc.charReady), 32'd0);
    chk("rst_cur", {cursorX, cursorY}, 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    wait_clear(W, K);

    for (int i = 0; i < 18; i++) begin
      send(vt[i].code, vt[i].fg, vt[i].bg);
      chk($sformatf("v%0d_wr", i), 32'(charWr), 32'(vt[i].wr));
      if (vt[i].wr) begin
        chk($sformatf("v%0d_code", i), 32'(charWrCode), 32'(vt[i].ecode));
        chk($sformatf("v%0d_x", i), 32'(charWrX), 32'(vt[i].ex));
        chk($sformatf("v%0d_y", i), 32'(charWrY), 32'(vt[i].ey));
        chk($sformatf("v%0d_fg", i), 32'(charWrFgColor), 32'(vt[i].fg));
        chk($sformatf("v%0d_bg", i), 32'(charWrBgColor), 32'(vt[i].bg));
      end
      chk($sformatf("v%0d_cx", i), 32'(cursorX), 32'(vt[i].cx));
      chk($sformatf("v%0d_cy", i), 32'(cursorY), 32'(vt[i].cy));
    end

    repeat (19) send(8'h0A, W, K);
    chk("lf_row23", {cursorX, cursorY}, {6'd0, 5'd23});
    repeat (63) send(8'h2E, W, K);
    chk("at_63_23", {cursorX, cursorY}, {6'd63, 5'd23});
    send(8'h5A, W, K);
    chk("wrap_wr", 32'(charWr), 32'd1);
    chk("wrap_xy", {charWrX, charWrY}, {6'd63, 5'd23});
    chk("wrap_cur", {cursorX, cursorY}, 32'd0);
`ifndef VGA_CONSOLE_CLEAR_ON_WRAP_EN
    chk("wrap_ready", 32'(ifc.charReady), 32'd1);
`endif
    while (!ifc.charReady) @(negedge CLOCK_50);
    send(8'h08, W, K);
    chk("bs00_wr", 32'(charWr), 32'd0);
    chk("bs00_cur", {cursorX, cursorY}, 32'd0);

    // Form feed followed by a byte held valid through the whole clear
    ifc.charValid = 1'b1;
    ifc.charCode  = 8'h0C;
    ifc.fgColor   = 24'h00FF00;
    ifc.bgColor   = 24'h112233;
    @(posedge CLOCK_50);
    #1 ifc.charCode = 8'h42;
    @(negedge CLOCK_50);
    n42 = 0;
    nclr = 0;
    done = 1'b0;
    it = 0;
    while (it < 3000 && !done) begin
      if (charWr) begin
        if (charWrCode == 8'h00) nclr++;
        else n42++;
      end
      if (ifc.charReady) begin
        @(posedge CLOCK_50);
        #1 ifc.charValid = 1'b0;
        @(negedge CLOCK_50);
        done = 1'b1;
      end else begin
        @(negedge CLOCK_50);
        it++;
      end
    end
    ifc.charValid = 1'b0;
    chk("ff_done", 32'(done), 32'd1);
    chk("ff_clr_count", 32'(nclr), 32'd1536);
    chk("ff_early_42", 32'(n42), 32'd0);
    chk("ff_42_wr", 32'(charWr), 32'd1);
    chk("ff_42_code", 32'(charWrCode), 32'h42);
    chk("ff_42_xy", {charWrX, charWrY}, 32'd0);
    chk("ff_cur", {cursorX, cursorY}, {6'd1, 5'd0});

    // Reset in the middle of a clear restarts it from scratch
    send(8'h0C, 24'h123456, 24'h654321);
    repeat (100) @(negedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_wr", 32'(charWr), 32'd0);
    chk("mid_rst_xy", {charWrX, charWrY}, 32'd0);
    chk("mid_rst_fg", 32'(charWrFgColor), 32'hFFFFFF);
    chk("mid_rst_ready", 32'(ifc.charReady), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    wait_clear(W, K);

`ifdef VGA_CONSOLE_CLEAR_ON_WRAP_EN
    repeat (7) send(8'h0A, W, K);
    repeat (10) send(8'h2E, W, K);
    chk("row_pre_cur", {cursorX, cursorY}, {6'd10, 5'd7});
    send(8'h0A, 24'hABCDEF, 24'h010203);
    chk("row_cur", {cursorX, cursorY}, {6'd0, 5'd8});
    begin
      int nw = 0;
      int lows = 0;
      int bad = 0;
      int k = 0;
      while (k < 200) begin
        if (!ifc.charReady) lows++;
        if (charWr) begin
          if (charWrX != 6'(nw) || charWrY != 5'd8 ||
              charWrCode != 8'h00 || charWrFgColor != 24'hABCDEF)
            bad++;
          nw++;
        end
        if (ifc.charReady) break;
        @(negedge CLOCK_50);
        k++;
      end
      chk("row_writes", 32'(nw), 32'd64);
      chk("row_order", 32'(bad), 32'd0);
      chk("row_low", 32'(lows), 32'd64);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout actual=%0d required=%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end
endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 SHALL have ports, clock and reset first: CLOCK_50 in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-002 SHALL have: charValid in 1 upstream byte valid; charCode in 8 upstream byte; charReady out 1 block can accept a byte.
REQ-003 SHALL have: fgColor in 24 foreground RGB; bgColor in 24 background RGB.
REQ-004 SHALL have registered outputs for the display's write port: charWr out 1; charWrFgColor out 24; charWrBgColor out 24; charWrCode out 8; charWrX out 6; charWrY out 5.
REQ-005 SHALL have: cursorX out 6; cursorY out 5, current cursor position.
REQ-006 SHALL have parameters: COLS default 64, text columns; ROWS default 24, text rows; BLANK default 8'h00, code written for erased cells.

Function
REQ-007 SHALL accept a byte on a CLOCK_50 edge where charValid && charReady; charReady SHALL equal (state==IDLE), combinational from state.
REQ-008 SHALL use states IDLE, CLR_SCREEN and CLR_ROW; every non-clear byte SHALL complete in one cycle, and the state SHALL remain IDLE.
REQ-009 SHALL handle printable bytes 8'h20..8'h7E with a charWr pulse on the next cycle, using code=charCode, X/Y=cursor before the edge, and colors=fgColor/bgColor sampled at accept.
REQ-010 SHALL advance the cursor after a printable byte: X+1. At X=COLS-1 the cursor SHALL go to X=0, Y+1. At Y=ROWS-1 Y SHALL wrap to 0.
REQ-011 SHALL handle 8'h0A (LF) with X=0, Y+1 and the same wrap; no write.
REQ-012 SHALL handle 8'h0D (CR) with X=0; no write.
REQ-013 SHALL handle 8'h08 (BS) as follows:
- X>0: cursor X-1, then write BLANK there.
- X=0, Y>0: cursor to (COLS-1, Y-1), then write BLANK there.
- (0,0): no-op, no write.
REQ-014 SHALL handle 8'h0C (FF) by entering CLR_SCREEN with colors latched at accept.
REQ-015 SHALL treat all other bytes as accepted and discarded: no write, no cursor change.
REQ-016 SHALL make CLR_SCREEN write BLANK to every cell, one per cycle, row-major from (0,0) to (COLS-1,ROWS-1), giving COLS*ROWS consecutive charWr cycles; it SHALL then set the cursor to (0,0) and return to IDLE.
REQ-017 SHALL set charWr to 0 in every cycle without a write, with the other write outputs holding their last values.
REQ-018 SHALL leave charValid ignored during CLR_SCREEN and CLR_ROW, with no byte lost or buffered.
REQ-019 SHALL compute all position arithmetic modulo COLS/ROWS; no X>=COLS or Y>=ROWS SHALL ever appear on any output.

Reset
REQ-020 SHALL asynchronously force, while reset is high: charWr=0, charWrCode=0, charWrX=0, charWrY=0, charWrFgColor=24'hFFFFFF, charWrBgColor=0, cursor=(0,0), state=CLR_SCREEN, clear counter=0.
REQ-021 SHALL, after reset deasserts, perform a full CLR_SCREEN (fg FFFFFF, bg 000000) with charReady low until it completes.
REQ-022 SHALL restart the clear from (0,0) when reset asserts mid-clear or mid-operation; there SHALL be no partial state carry-over.

Configuration
REQ-023 SHALL use macro VGA_CONSOLE_CLEAR_ON_WRAP_EN:
- Defined: any cursor move to a new row (auto-wrap or LF, including the ROWS-1 to 0 wrap) SHALL enter CLR_ROW. CLR_ROW SHALL write BLANK to all COLS cells of the new row, taking COLS cycles with charReady low, using the colors latched at accept, then return to IDLE.
- Undefined: CLR_ROW SHALL be unreachable and rows SHALL keep old content.

Verification
REQ-024 SHALL cover reset release: exactly 1536 charWr pulses with code 00, X/Y row-major, the last at (63,23); charReady rising on the following cycle; cursor (0,0).
REQ-025 SHALL cover sending 8'h41 with fg=FF0000, bg=0000FF at cursor (5,3): one cycle later charWr=1, code 41, X=5, Y=3, colors match; cursor becomes (6,3).
REQ-026 SHALL cover a printable at (63,23), macro undefined: write at (63,23), cursor (0,0), charReady stays high.
REQ-027 SHALL cover BS at (0,4): cursor (63,3) with BLANK written at (63,3); BS at (0,0): no charWr, cursor unchanged.
REQ-028 SHALL cover FF, then charValid held high with 8'h42 throughout: 1536 clear writes, then 8'h42 accepted exactly once at (0,0).
REQ-029 SHALL cover LF at (10,7), macro defined: cursor (0,8); 64 BLANK writes at Y=8, X 0..63; charReady low for 64 cycles.
